// File: rtl/viterbi_decoder_p.sv
// Viterbi decoder: serial forward recursion over destination states,
// traceback into a path memory, then in-order emission of the path.
module viterbi_decoder_p #(
    parameter int S = 4,
    parameter int K = 4,
    parameter int L = 16,
    parameter int W = 16,
    localparam int SW = $clog2(S),
    localparam int KW = $clog2(K),
    localparam int LW = $clog2(L + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LW-1:0]         length,
    input  logic [KW-1:0]         obs,
    input  logic                  obs_valid,
    output logic                  obs_ready,
    input  logic [S*S*W-1:0]      logA,
    input  logic [S*W-1:0]        logC,
    input  logic [S*K*W-1:0]      logB,
    output logic [SW-1:0]         path_state,
    output logic [LW-1:0]         path_idx,
    output logic                  path_valid,
    input  logic                  path_ready,
    output logic                  path_last,
    output logic signed [W-1:0]   best_score,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int TW = $clog2(L);
    localparam logic [LW-1:0] LMAX = LW'(L);
    localparam logic [SW-1:0] JMAX = SW'(S - 1);

    typedef enum logic [2:0] {IDLE, INIT, FWD, TRACE, EMIT} state_t;

    state_t state, state_nx;

    logic [LW-1:0] t, len_q, e;
    logic [SW-1:0] jc, cur;
    logic [KW-1:0] obs_q, obs_sel;
    logic          stepping, tfirst;

    logic signed [W-1:0] delta [S];
    logic signed [W-1:0] dnext [S];
    logic signed [W-1:0] cand [S];
    logic signed [W-1:0] init_val [S];
    logic signed [W-1:0] step_max, step_new, fin_max;
    logic [SW-1:0]       step_arg, fin_arg, psi_rd;

    logic [SW-1:0] psi [L][S];
    logic [SW-1:0] path [L];

    logic len_ok, step_fire, hs;

    function automatic logic signed [W-1:0] sat_add(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction

    assign len_ok     = (length != '0) && (length <= LMAX);
    assign busy       = (state != IDLE);
    assign obs_ready  = (state == INIT) || ((state == FWD) && !stepping);
    assign step_fire  = (state == FWD) && (stepping || obs_valid);
    assign path_valid = (state == EMIT);
    assign hs         = path_valid && path_ready;
    assign path_idx   = path_valid ? e : '0;
    assign path_state = path_valid ? path[e[TW-1:0]] : '0;
    assign path_last  = path_valid && (e == len_q - LW'(1));
    assign obs_sel    = stepping ? obs_q : obs;
    assign psi_rd     = psi[t[TW-1:0]][cur];

    // Candidate scores into destination jc, best predecessor and new delta.
    always_comb begin
        for (int i = 0; i < S; i++)
            cand[i] = sat_add(delta[i], logA[(i*S + int'(jc))*W +: W]);
        step_max = cand[0];
        step_arg = '0;
        for (int i = 1; i < S; i++) begin
            if (cand[i] > step_max) begin
                step_max = cand[i];
                step_arg = SW'(i);
            end
        end
        step_new = sat_add(step_max,
                           logB[(int'(jc)*K + int'(obs_sel))*W +: W]);
    end

    // First-observation deltas for all states in parallel.
    always_comb begin
        for (int j = 0; j < S; j++)
            init_val[j] = sat_add(logC[j*W +: W],
                                  logB[(j*K + int'(obs))*W +: W]);
    end

    // Final-state selection over delta, lowest index wins ties.
    always_comb begin
        fin_max = delta[0];
        fin_arg = '0;
        for (int i = 1; i < S; i++) begin
            if (delta[i] > fin_max) begin
                fin_max = delta[i];
                fin_arg = SW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start && len_ok) state_nx = INIT;
            INIT:  if (obs_valid)
                       state_nx = (len_q == LW'(1)) ? TRACE : FWD;
            FWD:   if (step_fire && (jc == JMAX) &&
                       (t == len_q - LW'(1)))
                       state_nx = TRACE;
            TRACE: if (tfirst ? (t == '0) : (t == LW'(1)))
                       state_nx = EMIT;
            EMIT:  if (hs && path_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: counters, delta buffers, score and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t          <= '0;
            len_q      <= '0;
            e          <= '0;
            jc         <= '0;
            cur        <= '0;
            obs_q      <= '0;
            stepping   <= 1'b0;
            tfirst     <= 1'b0;
            best_score <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < S; i++) begin
                delta[i] <= '0;
                dnext[i] <= '0;
            end
        end else begin
            err  <= (state == IDLE) && start && !len_ok;
            done <= hs && path_last;
            unique case (state)
                IDLE: begin
                    if (start && len_ok) begin
                        len_q    <= length;
                        t        <= '0;
                        e        <= '0;
                        jc       <= '0;
                        stepping <= 1'b0;
                    end
                end
                INIT: begin
                    if (obs_valid) begin
                        for (int j = 0; j < S; j++)
                            delta[j] <= init_val[j];
                        t      <= (len_q == LW'(1)) ? '0 : LW'(1);
                        tfirst <= (len_q == LW'(1));
                    end
                end
                FWD: begin
                    if (step_fire) begin
                        dnext[jc] <= step_new;
                        if (!stepping) obs_q <= obs;
                        stepping <= 1'b1;
                        if (jc == JMAX) begin
                            for (int i = 0; i < S; i++)
                                delta[i] <= (i == S - 1) ? step_new
                                                         : dnext[i];
                            jc       <= '0;
                            stepping <= 1'b0;
                            if (t == len_q - LW'(1)) tfirst <= 1'b1;
                            else                     t <= t + LW'(1);
                        end else begin
                            jc <= jc + SW'(1);
                        end
                    end
                end
                TRACE: begin
                    if (tfirst) begin
                        cur        <= fin_arg;
                        best_score <= fin_max;
                        tfirst     <= 1'b0;
                    end else begin
                        cur <= psi_rd;
                        t   <= t - LW'(1);
                    end
                end
                EMIT: begin
                    if (hs) e <= e + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // Survivor and path memories; contents are always written before use.
    always_ff @(posedge clk) begin
        if (step_fire)
            psi[t[TW-1:0]][jc] <= step_arg;
        if (state == TRACE) begin
            if (tfirst) path[t[TW-1:0]]         <= fin_arg;
            else        path[TW'(t - LW'(1))]   <= psi_rd;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_p.sv
// Scoreboard bench for viterbi_decoder_p with hand-computed paths.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_viterbi_decoder_p;

    localparam int S  = 2;
    localparam int K  = 2;
    localparam int L  = 16;
    localparam int W  = 16;
    localparam int SW = 1;
    localparam int KW = 1;
    localparam int LW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LW-1:0]        length = '0;
    logic [KW-1:0]        obs = '0;
    logic                 obs_valid = 1'b0;
    logic                 obs_ready;
    logic [S*S*W-1:0]     logA = '0;
    logic [S*W-1:0]       logC = '0;
    logic [S*K*W-1:0]     logB = '0;
    logic [SW-1:0]        path_state;
    logic [LW-1:0]        path_idx;
    logic                 path_valid;
    logic                 path_ready = 1'b1;
    logic                 path_last;
    logic signed [W-1:0]  best_score;
    logic                 busy, done, err;

    viterbi_decoder_p #(.S(S), .K(K), .L(L), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .obs(obs), .obs_valid(obs_valid), .obs_ready(obs_ready),
        .logA(logA), .logC(logC), .logB(logB),
        .path_state(path_state), .path_idx(path_idx),
        .path_valid(path_valid), .path_ready(path_ready),
        .path_last(path_last), .best_score(best_score),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int idx;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    best_q[$];
    int    checks = 0;
    int    passed = 0;
    int    done_cnt = 0;
    int    err_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: scoreboard pops, stall stability, done pulse tracking.
    logic stall_prev = 1'b0;
    logic exp_done = 1'b0;
    int   snap_st, snap_idx, snap_last;
    always @(negedge clk) begin
        beat_t b;
        int    eb;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (exp_done) begin
            chk("done_pulse", int'(done), 1);
            exp_done = 1'b0;
        end
        if (stall_prev) begin
            chk("stall_state", int'(path_state), snap_st);
            chk("stall_idx", int'(path_idx), snap_idx);
            chk("stall_last", int'(path_last), snap_last);
        end
        stall_prev = path_valid && !path_ready;
        snap_st    = int'(path_state);
        snap_idx   = int'(path_idx);
        snap_last  = int'(path_last);
        if (path_valid && path_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", int'(path_idx), -1);
            end else begin
                b = exp_q.pop_front();
                chk("path_state", int'(path_state), b.st);
                chk("path_idx", int'(path_idx), b.idx);
                chk("path_last", int'(path_last), b.last);
                if (b.last != 0) begin
                    eb = best_q.pop_front();
                    chk("best_score", int'($signed(best_score)), eb);
                    exp_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!obs_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("obs_ready_timeout", 0, 1);
    endtask

    task automatic set_ref();
        for (int i = 0; i < S; i++)
            for (int j = 0; j < S; j++)
                logA[(i*S+j)*W +: W] = (i == j) ? 16'd0 : 16'(-100);
        logC[0 +: W] = 16'd0;
        logC[W +: W] = 16'(-100);
        for (int j = 0; j < S; j++)
            for (int k = 0; k < K; k++)
                logB[(j*K+k)*W +: W] = (j == k) ? 16'd0 : 16'(-60);
    endtask

    task automatic set_zero();
        logA = '0;
        logC = '0;
        logB = '0;
    endtask

    task automatic set_sat();
        logA = '0;
        for (int i = 0; i < S; i++) logC[i*W +: W] = 16'h8000;
        for (int i = 0; i < S*K; i++) logB[i*W +: W] = 16'hFFFF;
    endtask

    task automatic run(input int len, input int ov[4], input int ep[4],
                       input int eb, input int gap, input bit stall);
        int k;
        for (int n = 0; n < len; n++)
            exp_q.push_back('{ep[n], n, int'(n == len - 1)});
        best_q.push_back(eb);
        start  = 1'b1;
        length = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < len; n++) begin
            if (n > 0)
                repeat (gap) begin @(posedge clk); #1; end
            obs       = KW'(ov[n]);
            obs_valid = 1'b1;
            wait_ready();
            @(posedge clk); #1;
            obs_valid = 1'b0;
        end
        if (stall) begin
            k = 0;
            while (!(path_valid && path_idx == 1) && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            if (k >= 200) chk("beat1_timeout", 0, 1);
            path_ready = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            path_ready = 1'b1;
        end
        k = 0;
        while (busy && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) chk("busy_timeout", 0, 1);
        @(posedge clk); #1;
        chk("beats_left", exp_q.size(), 0);
    endtask

    task automatic bad_len(input int len);
        start  = 1'b1;
        length = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_obs_ready", int'(obs_ready), 0);
        @(posedge clk); #1;
        chk("err_clear", int'(err), 0);
        chk("err_busy2", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_obs_ready", int'(obs_ready), 0);
        chk("rst_path_valid", int'(path_valid), 0);
        chk("rst_best", int'($signed(best_score)), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_ref();
        run(4, '{0, 0, 1, 1}, '{0, 0, 1, 1}, -100, 0, 1'b0);
        chk("best_hold", int'($signed(best_score)), -100);

        set_zero();
        run(3, '{1, 0, 1, 0}, '{0, 0, 0, 0}, 0, 0, 1'b0);

        set_sat();
        run(3, '{0, 1, 0, 0}, '{0, 0, 0, 0}, -32768, 0, 1'b0);

        bad_len(0);
        bad_len(L + 1);

        set_ref();
        run(4, '{0, 0, 1, 1}, '{0, 0, 1, 1}, -100, 3, 1'b1);

        start  = 1'b1;
        length = LW'(4);
        @(posedge clk); #1;
        start     = 1'b0;
        obs       = 1'b0;
        obs_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        wait_ready();
        @(posedge clk); #1;
        obs_valid = 1'b0;
        chk("mid_fwd_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_obs_ready", int'(obs_ready), 0);
        chk("abort_path_valid", int'(path_valid), 0);
        chk("abort_best", int'($signed(best_score)), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(4, '{0, 0, 1, 1}, '{0, 0, 1, 1}, -100, 0, 1'b0);

        chk("done_count", done_cnt, 5);
        chk("err_count", err_cnt, 2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
